// File: rtl/ssp_pkg.sv
// Shared SSP constants used by the receive and transmit FIFOs.
package ssp_pkg;

  localparam int SSP_DATA_W     = 8;
  localparam int SSP_FIFO_DEPTH = 4;

  typedef logic [SSP_DATA_W-1:0] ssp_byte_t;

endpackage

// File: rtl/ssp_fifo_mem.sv
// FIFO storage: register array, one synchronous write port, one combinational read port.
module ssp_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear_b,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] entry_q [DEPTH];

  // Each entry is its own register so clearing and writing stay per-slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    always_ff @(posedge clk) begin
      if (!clear_b) begin
        entry_reg <= '0;
      end else if (wr_en && (wr_addr == AW'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  assign rd_data = entry_q[rd_addr];

endmodule

// File: rtl/ssp_rxfifo.sv
// SSP receive FIFO: bytes pushed by rx_valid, popped once per APB read onto a registered PRDATA.
module ssp_rxfifo
  import ssp_pkg::*;
#(
  parameter int WIDTH = SSP_DATA_W,
  parameter int DEPTH = SSP_FIFO_DEPTH
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] RxData,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] PRDATA,
  output logic             rx_empty,
  output logic             SSPRXINTR,
  output logic             rx_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] prdata_reg, prdata_next;
  logic             overrun_reg, overrun_next;
  logic             empty_reg, full_reg, rd_hist_reg;
  logic             rd_access, rd_req, pop, push;
  logic [WIDTH-1:0] mem_rd_data;

  // A held PSEL only counts once: the request is the rising edge of a read access.
  assign rd_access = PSEL & ~PWRITE;
  assign rd_req    = rd_access & ~rd_hist_reg;
  assign pop       = rd_req & (count_reg != '0);
  assign push      = rx_valid & ((count_reg != FULL_COUNT) | pop);

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    prdata_next  = prdata_reg;
    overrun_next = overrun_reg;

    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // No bypass: an empty read returns zero even if a byte arrives this cycle.
    if (rd_req) prdata_next = pop ? mem_rd_data : '0;

    if (pop)                  overrun_next = 1'b0;
    else if (rx_valid & ~push) overrun_next = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      prdata_reg  <= '0;
      overrun_reg <= 1'b0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      rd_hist_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      prdata_reg  <= prdata_next;
      overrun_reg <= overrun_next;
      empty_reg   <= (count_next == '0);
      full_reg    <= (count_next == FULL_COUNT);
      rd_hist_reg <= rd_access;
    end
  end

  ssp_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (PCLK),
    .clear_b (CLEAR_B),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (RxData),
    .rd_addr (rd_ptr_reg),
    .rd_data (mem_rd_data)
  );

  assign PRDATA     = prdata_reg;
  assign rx_empty   = empty_reg;
  assign SSPRXINTR  = full_reg;
  assign rx_overrun = overrun_reg;

endmodule

// File: doc/ssp_rxfifo.md
SSP_RXFIFO -- requirements
Module: ssp_rxfifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data byte width.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-003 The block SHALL have port PCLK  input  1  sole clock, all state updates on its rising edge.
REQ-004 The block SHALL have port CLEAR_B  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port PSEL  input  1  APB select.
REQ-006 The block SHALL have port PWRITE  input  1  APB direction; 0 = read.
REQ-007 The block SHALL have port RxData  input  WIDTH  byte from the serial receive logic.
REQ-008 The block SHALL have port rx_valid  input  1  one-cycle pulse; RxData is valid in that cycle.
REQ-009 The block SHALL have port PRDATA  output  WIDTH  popped byte, registered.
REQ-010 The block SHALL have port rx_empty  output  1  FIFO holds no entries.
REQ-011 The block SHALL have port SSPRXINTR  output  1  FIFO full interrupt.
REQ-012 The block SHALL have port rx_overrun  output  1  sticky flag: a received byte was dropped.

Function
REQ-013 State SHALL be: storage array; wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH; count, log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-014 Read request SHALL be rd_req = PSEL & ~PWRITE & ~(registered PSEL & ~PWRITE of the previous cycle), i.e. one pop per APB read, however long PSEL is held.
REQ-015 Pop: rd_req with count>0 SHALL load PRDATA with mem[rd_ptr] at the next edge and increment rd_ptr; latency is one cycle.
REQ-016 rd_req with count==0 SHALL load PRDATA with 0 and leave the pointers unchanged; there SHALL be no write-to-read bypass.
REQ-017 PRDATA SHALL hold its value between pops.
REQ-018 Push: rx_valid with count<DEPTH SHALL write RxData to mem[wr_ptr] and increment wr_ptr.
REQ-019 rx_valid with count==DEPTH and no pop in the same cycle SHALL drop RxData, leave the storage unchanged, and set rx_overrun.
REQ-020 A push and a pop in the same cycle when full SHALL both take effect; count stays DEPTH and rx_overrun is not set.
REQ-021 A push and a pop in the same cycle when empty SHALL store the byte, return 0 on PRDATA, and give count=1.
REQ-022 count SHALL change by +1 on a push only, -1 on a pop only, and 0 on both or neither.
REQ-023 rx_empty SHALL equal (count==0) and SSPRXINTR SHALL equal (count==DEPTH), both registered and consistent with count after each edge.
REQ-024 rx_overrun SHALL clear on the first successful pop after it is set; a pop and an overrun in the same cycle are impossible per REQ-020.

Reset
REQ-025 When CLEAR_B==0 at a PCLK edge, the block SHALL set pointers, count and storage to 0, PRDATA=0, rx_empty=1, SSPRXINTR=0, rx_overrun=0, and the rd_req history register to 0.
REQ-026 Reset SHALL override any push or pop in the same cycle; bytes in flight are discarded.
REQ-027 The block SHALL have no initial blocks or asynchronous reset paths.

Structure
REQ-028 Package ssp_pkg SHALL hold SSP_DATA_W=8 and SSP_FIFO_DEPTH=4, shared with the transmit FIFO.
REQ-029 Storage SHALL be one sub-module, ssp_fifo_mem: a register array with one synchronous write port and one combinational read port; pointer, count and flag logic stay in ssp_rxfifo.

Verification
REQ-030 Push 0x11,0x22,0x33 via rx_valid, then three separate APB reads -> PRDATA 0x11,0x22,0x33, each one cycle after rd_req; rx_empty=1 afterwards.
REQ-031 Push 0xA0..0xA3 -> SSPRXINTR=1 after the 4th push; push 0xA4 -> rx_overrun=1 and dropped; read -> 0xA0, rx_overrun=0, SSPRXINTR=0.
REQ-032 With the FIFO full (0xB0..0xB3), push 0xB4 and read in the same cycle -> PRDATA=0xB0, count=4, no overrun; the remaining reads return 0xB1..0xB4.
REQ-033 Hold PSEL=1, PWRITE=0 for 5 cycles with 2 entries stored -> exactly one pop; count=1.
REQ-034 Read when empty -> PRDATA=0x00 and pointers unchanged; push 0x5A in the same cycle -> count=1, and the next read returns 0x5A.
REQ-035 Fill with 3 entries, assert CLEAR_B=0 for one cycle with a simultaneous rx_valid -> all outputs at reset values and count=0; wrap-around is exercised by 10 push/pop pairs returning data in order.
